// File: rtl/next_pc_pkg.sv
`default_nettype none
// =============================================================================
// next_pc_pkg : shared types and defaults for the next-PC unit
// Rev 1.0
// =============================================================================
package next_pc_pkg;

    localparam int AW_DEF = 16;
    localparam logic [15:0] RESET_VEC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1
    } state_t;

    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage : next_pc_pkg
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// =============================================================================
// ras_stack : circular return-address stack; a push while full drops the oldest
// Rev 1.0
// =============================================================================
module ras_stack
    import next_pc_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [AW-1:0]               push_data,
    input  logic                        pop,
    output logic [AW-1:0]               top_data,
    output logic                        full,
    output logic                        empty,
    output logic [ras_ptr_w(DEPTH):0]   cnt,
    output logic                        ovf_evt,
    output logic                        unf_evt
);

    localparam int PW = ras_ptr_w(DEPTH);
    localparam logic [PW-1:0] c_ptr_one = PW'(1);
    localparam logic [PW:0]   c_cnt_one = (PW+1)'(1);
    localparam logic [PW:0]   c_cnt_max = (PW+1)'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW:0]   r_cnt;

    // r_wp is the next free slot; the top of stack sits just below it
    assign top_data = r_mem[r_wp - c_ptr_one];
    assign full     = (r_cnt == c_cnt_max);
    assign empty    = (r_cnt == '0);
    assign cnt      = r_cnt;
    assign ovf_evt  = push & full;
    assign unf_evt  = pop & empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_wp <= r_wp + c_ptr_one;
            if (!full) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end else if (pop && !empty) begin
            r_wp  <= r_wp - c_ptr_one;
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            r_mem[r_wp] <= push_data;
        end
    end

endmodule : ras_stack
`default_nettype wire

// File: rtl/next_pc_unit.sv
`default_nettype none
// =============================================================================
// next_pc_unit : priority next-address mux with RUN/HALT control and a RAS
// Rev 1.0
// =============================================================================
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter int            AW        = AW_DEF,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [AW-1:0]                   pc,
    input  logic                            stall,
    input  logic                            br_taken,
    input  logic [AW-1:0]                   br_target,
    input  logic                            call,
    input  logic [AW-1:0]                   call_target,
    input  logic                            ret,
    input  logic                            halt,
    input  logic                            resume,
    output logic [AW-1:0]                   next_pc,
    output logic                            flush,
    output logic                            halted,
    output logic [ras_ptr_w(RAS_DEPTH):0]   ras_cnt,
    output logic                            ras_ovf,
    output logic                            ras_unf
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_flush;
    logic          r_halted;
    logic          r_ras_ovf;
    logic          r_ras_unf;

    logic [AW-1:0] w_pc_inc;
    logic          w_redirect;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_ras_top;
    logic          w_ras_full;
    logic          w_ras_empty;
    logic          w_ovf_evt;
    logic          w_unf_evt;

    assign w_pc_inc = pc + AW'(1);

    ras_stack #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_pc_inc),
        .pop       (w_pop),
        .top_data  (w_ras_top),
        .full      (w_ras_full),
        .empty     (w_ras_empty),
        .cnt       (ras_cnt),
        .ovf_evt   (w_ovf_evt),
        .unf_evt   (w_unf_evt)
    );

    always_comb begin
        next_pc     = w_pc_inc;
        w_state_nxt = r_state;
        w_redirect  = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (!rst_n) begin
            next_pc = RESET_VEC;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (stall) begin
                        next_pc = pc;
                    end else if (br_taken) begin
                        next_pc    = br_target;
                        w_redirect = 1'b1;
                    end else if (ret) begin
                        // empty-stack pop only raises the underflow event
                        w_pop = 1'b1;
                        if (!w_ras_empty) begin
                            next_pc    = w_ras_top;
                            w_redirect = 1'b1;
                        end
                    end else if (call) begin
                        next_pc    = call_target;
                        w_push     = 1'b1;
                        w_redirect = 1'b1;
                    end else if (halt) begin
                        next_pc     = pc;
                        w_state_nxt = ST_HALT;
                    end
                end
                ST_HALT: begin
                    next_pc = pc;
                    if (resume && !stall) begin
                        next_pc     = w_pc_inc;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_flush   <= 1'b0;
            r_halted  <= 1'b0;
            r_ras_ovf <= 1'b0;
            r_ras_unf <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_flush   <= w_redirect;
            r_halted  <= (w_state_nxt == ST_HALT);
            r_ras_ovf <= r_ras_ovf | (w_ovf_evt & w_ras_full);
            r_ras_unf <= r_ras_unf | w_unf_evt;
        end
    end

    assign flush   = r_flush;
    assign halted  = r_halted;
    assign ras_ovf = r_ras_ovf;
    assign ras_unf = r_ras_unf;

endmodule : next_pc_unit
`default_nettype wire

// File: tb/tb_next_pc_unit.sv
`default_nettype none
// =============================================================================
// tb_next_pc_unit : scoreboard bench for next_pc_unit
// Rev 1.0
// =============================================================================
module tb_next_pc_unit;

    localparam int AW        = 16;
    localparam int RAS_DEPTH = 4;
    localparam int CW        = $clog2(RAS_DEPTH) + 1;

    localparam int c_sel_pc   = 0;
    localparam int c_sel_fl   = 1;
    localparam int c_sel_halt = 2;
    localparam int c_sel_cnt  = 3;
    localparam int c_sel_ovf  = 4;
    localparam int c_sel_unf  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc;
    logic          stall;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          call;
    logic [AW-1:0] call_target;
    logic          ret;
    logic          halt;
    logic          resume;
    logic [AW-1:0] next_pc;
    logic          flush;
    logic          halted;
    logic [CW-1:0] ras_cnt;
    logic          ras_ovf;
    logic          ras_unf;

    next_pc_unit #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_VEC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .call        (call),
        .call_target (call_target),
        .ret         (ret),
        .halt        (halt),
        .resume      (resume),
        .next_pc     (next_pc),
        .flush       (flush),
        .halted      (halted),
        .ras_cnt     (ras_cnt),
        .ras_ovf     (ras_ovf),
        .ras_unf     (ras_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          sel;
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t q[$];
    int  cyc     = 0;
    int  n_cmp   = 0;
    int  n_err   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] obs_of(input int sel);
        case (sel)
            c_sel_pc:   return 32'(next_pc);
            c_sel_fl:   return 32'(flush);
            c_sel_halt: return 32'(halted);
            c_sel_cnt:  return 32'(ras_cnt);
            c_sel_ovf:  return 32'(ras_ovf);
            default:    return 32'(ras_unf);
        endcase
    endfunction

    // dly 0: check in the current cycle; dly 1: check after the coming edge
    task automatic expect_at(input int dly, input int sel, input string tag, input logic [31:0] v);
        sb_t e;
        e.due = cyc + dly;
        e.sel = sel;
        e.tag = tag;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic drain();
        sb_t keep[$];
        sb_t e;
        keep = {};
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.due <= cyc) check_val(e.tag, obs_of(e.sel), e.exp);
            else              keep.push_back(e);
        end
        q = keep;
    endtask

    task automatic drv(input logic [AW-1:0] p, input logic st, input logic br,
                       input logic [AW-1:0] bt, input logic c, input logic [AW-1:0] ct,
                       input logic r, input logic h, input logic rs);
        pc          = p;
        stall       = st;
        br_taken    = br;
        br_target   = bt;
        call        = c;
        call_target = ct;
        ret         = r;
        halt        = h;
        resume      = rs;
    endtask

    task automatic idle(input logic [AW-1:0] p);
        drv(p, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        #1;
        drain();
        @(posedge clk);
        #1;
        cyc++;
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        idle(16'h1234);

        // reset: PC loads the reset vector
        for (int i = 0; i < 2; i++) begin
            expect_at(0, c_sel_pc, "rst_next_pc", 32'h0000);
            step();
        end
        rst_n = 1'b1;

        // increment and wrap
        idle(16'hFFFE);
        expect_at(0, c_sel_fl,   "rst_flush",  0);
        expect_at(0, c_sel_halt, "rst_halted", 0);
        expect_at(0, c_sel_cnt,  "rst_cnt",    0);
        expect_at(0, c_sel_ovf,  "rst_ovf",    0);
        expect_at(0, c_sel_unf,  "rst_unf",    0);
        expect_at(0, c_sel_pc,   "inc",        32'hFFFF);
        expect_at(1, c_sel_fl,   "inc_flush",  0);
        step();
        idle(16'hFFFF);
        expect_at(0, c_sel_pc, "wrap",       32'h0000);
        expect_at(1, c_sel_fl, "wrap_flush", 0);
        step();

        // branch, then the same branch under stall
        drv(16'h0010, 1'b0, 1'b1, 16'h0400, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        expect_at(0, c_sel_pc, "br_pc",    32'h0400);
        expect_at(1, c_sel_fl, "br_flush", 1);
        step();
        drv(16'h0010, 1'b1, 1'b1, 16'h0400, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        expect_at(0, c_sel_pc, "stall_pc",    32'h0010);
        expect_at(1, c_sel_fl, "stall_flush", 0);
        step();

        // call / return / underflow
        drv(16'h0020, 1'b0, 1'b0, '0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        expect_at(0, c_sel_pc,  "call_pc",    32'h0100);
        expect_at(1, c_sel_cnt, "call_cnt",   1);
        expect_at(1, c_sel_fl,  "call_flush", 1);
        step();
        drv(16'h0105, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        expect_at(0, c_sel_pc,  "ret_pc",    32'h0021);
        expect_at(1, c_sel_cnt, "ret_cnt",   0);
        expect_at(1, c_sel_fl,  "ret_flush", 1);
        step();
        drv(16'h0105, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        expect_at(0, c_sel_pc,  "unf_pc",    32'h0106);
        expect_at(1, c_sel_unf, "unf_flag",  1);
        expect_at(1, c_sel_fl,  "unf_flush", 0);
        step();

        // call+ret together: only the ret (empty) acts, no push
        drv(16'h0200, 1'b0, 1'b0, '0, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0);
        expect_at(0, c_sel_pc,  "callret_pc",  32'h0201);
        expect_at(1, c_sel_cnt, "callret_cnt", 0);
        step();

        // overflow: five calls into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            drv(AW'(i), 1'b0, 1'b0, '0, 1'b1, 16'h0800, 1'b0, 1'b0, 1'b0);
            expect_at(0, c_sel_pc, "ovf_call_pc", 32'h0800);
            expect_at(1, c_sel_fl, "b2b_flush",   1);
            if (i == 4) expect_at(1, c_sel_ovf, "ovf_early", 0);
            step();
        end
        expect_at(0, c_sel_cnt, "ovf_cnt",  4);
        expect_at(0, c_sel_ovf, "ovf_flag", 1);
        for (int i = 0; i < 4; i++) begin
            drv(16'h0900, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            expect_at(0, c_sel_pc, "ovf_ret_pc", 32'(6 - i));
            step();
        end
        expect_at(0, c_sel_cnt, "ovf_drained", 0);
        expect_at(0, c_sel_ovf, "ovf_sticky",  1);

        // halt, ignored requests, stalled resume, resume
        drv(16'h0050, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        expect_at(0, c_sel_pc,   "halt_pc",    32'h0050);
        expect_at(1, c_sel_halt, "halt_flag",  1);
        step();
        drv(16'h0050, 1'b0, 1'b1, 16'h0400, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        expect_at(0, c_sel_pc,   "halt_br_pc",    32'h0050);
        expect_at(1, c_sel_fl,   "halt_br_flush", 0);
        expect_at(1, c_sel_halt, "halt_hold",     1);
        step();
        drv(16'h0050, 1'b0, 1'b0, '0, 1'b1, 16'h0700, 1'b0, 1'b0, 1'b0);
        expect_at(0, c_sel_pc,  "halt_call_pc",  32'h0050);
        expect_at(1, c_sel_cnt, "halt_call_cnt", 0);
        step();
        drv(16'h0050, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        expect_at(0, c_sel_pc,   "halt_stall_pc", 32'h0050);
        expect_at(1, c_sel_halt, "halt_stall",    1);
        step();
        drv(16'h0050, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        expect_at(0, c_sel_pc,   "resume_pc",    32'h0051);
        expect_at(1, c_sel_halt, "resume_flag",  0);
        expect_at(1, c_sel_fl,   "resume_flush", 0);
        step();

        // reset mid-operation discards a pending flush and stack contents
        drv(16'h0030, 1'b0, 1'b0, '0, 1'b1, 16'h0600, 1'b0, 1'b0, 1'b0);
        expect_at(1, c_sel_cnt, "pre_rst_cnt", 1);
        step();
        rst_n = 1'b0;
        idle(16'h0777);
        expect_at(0, c_sel_pc,  "mid_rst_pc",  32'h0000);
        expect_at(1, c_sel_fl,  "mid_rst_fl",  0);
        expect_at(1, c_sel_cnt, "mid_rst_cnt", 0);
        expect_at(1, c_sel_ovf, "mid_rst_ovf", 0);
        expect_at(1, c_sel_unf, "mid_rst_unf", 0);
        step();
        rst_n = 1'b1;
        drv(16'h0600, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        expect_at(0, c_sel_pc,  "post_rst_ret", 32'h0601);
        expect_at(1, c_sel_unf, "post_rst_unf", 1);
        step();

        if (q.size() != 0) check_val("sb_leftover", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_next_pc_unit
`default_nettype wire
